// File: rtl/axi_atop_id_guard.sv
// Per-ID ordering guard: holds AW/AR handshakes so an atomic issues only on an
// idle ID and nothing else with that ID issues until its responses return.
module axi_atop_id_guard #(
    parameter int unsigned IdWidth = 4,
    parameter int unsigned MaxTxns = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               slv_aw_valid_i,
    output logic               slv_aw_ready_o,
    input  logic [IdWidth-1:0] aw_id_i,
    input  logic [5:0]         aw_atop_i,
    output logic               mst_aw_valid_o,
    input  logic               mst_aw_ready_i,
    input  logic               slv_ar_valid_i,
    output logic               slv_ar_ready_o,
    input  logic [IdWidth-1:0] ar_id_i,
    output logic               mst_ar_valid_o,
    input  logic               mst_ar_ready_i,
    input  logic               b_valid_i,
    input  logic               b_ready_i,
    input  logic [IdWidth-1:0] b_id_i,
    input  logic               r_valid_i,
    input  logic               r_ready_i,
    input  logic               r_last_i,
    input  logic [IdWidth-1:0] r_id_i,
    output logic               idle_o,
    output logic               err_o
);

    localparam int unsigned NumIds = 2 ** IdWidth;
    localparam int unsigned CntW   = $clog2(MaxTxns + 1);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t MaxCnt = cnt_t'(MaxTxns);
    localparam cnt_t One    = cnt_t'(1);

    cnt_t              wr_cnt_q [NumIds];
    cnt_t              wr_cnt_d [NumIds];
    cnt_t              rd_cnt_q [NumIds];
    cnt_t              rd_cnt_d [NumIds];
    logic [NumIds-1:0] busy_q;
    logic [NumIds-1:0] busy_d;
    logic              err_q;
    logic              err_d;
    logic              idle_q;
    logic              idle_d;

    logic aw_atomic;
    logic aw_allow;
    logic ar_allow;
    logic aw_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;
    logic atop_unused;

    assign atop_unused = ^aw_atop_i[3:0];

    assign aw_atomic = aw_atop_i[5:4] != 2'b00;

    // Allow terms look only at registered state, never at downstream ready.
    always_comb begin
        aw_allow = !busy_q[aw_id_i];
        if (aw_atomic) begin
            aw_allow = aw_allow && wr_cnt_q[aw_id_i] == '0
                                && rd_cnt_q[aw_id_i] == '0;
        end else begin
            aw_allow = aw_allow && wr_cnt_q[aw_id_i] < MaxCnt;
        end
        ar_allow = !busy_q[ar_id_i] && rd_cnt_q[ar_id_i] < MaxCnt
                   && !(slv_aw_valid_i && aw_atomic && aw_id_i == ar_id_i);
    end

    assign mst_aw_valid_o = slv_aw_valid_i & aw_allow;
    assign slv_aw_ready_o = mst_aw_ready_i & aw_allow;
    assign mst_ar_valid_o = slv_ar_valid_i & ar_allow;
    assign slv_ar_ready_o = mst_ar_ready_i & ar_allow;

    assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
    assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i;

    logic wr_inc;
    logic wr_dec;
    logic rd_inc;
    logic rd_dec;
    logic aw_hit;

    always_comb begin
        err_d  = 1'b0;
        wr_inc = 1'b0;
        wr_dec = 1'b0;
        rd_inc = 1'b0;
        rd_dec = 1'b0;
        aw_hit = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            aw_hit = aw_hs && aw_id_i == IdWidth'(i);
            wr_inc = aw_hit;
            wr_dec = b_hs && b_id_i == IdWidth'(i);
            rd_inc = (aw_hit && aw_atop_i[5])
                     || (ar_hs && ar_id_i == IdWidth'(i));
            rd_dec = r_hs && r_id_i == IdWidth'(i);

            wr_cnt_d[i] = wr_cnt_q[i];
            if (wr_inc && !wr_dec) begin
                wr_cnt_d[i] = wr_cnt_q[i] + One;
            end else if (wr_dec && !wr_inc) begin
                if (wr_cnt_q[i] == '0) err_d = 1'b1;
                else wr_cnt_d[i] = wr_cnt_q[i] - One;
            end

            rd_cnt_d[i] = rd_cnt_q[i];
            if (rd_inc && !rd_dec) begin
                rd_cnt_d[i] = rd_cnt_q[i] + One;
            end else if (rd_dec && !rd_inc) begin
                if (rd_cnt_q[i] == '0) err_d = 1'b1;
                else rd_cnt_d[i] = rd_cnt_q[i] - One;
            end

            busy_d[i] = busy_q[i];
            if (aw_hit && aw_atomic) begin
                busy_d[i] = 1'b1;
            end else if (wr_cnt_d[i] == '0 && rd_cnt_d[i] == '0) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        idle_d = busy_q == '0;
        for (int i = 0; i < NumIds; i++) begin
            if (wr_cnt_q[i] != '0 || rd_cnt_q[i] != '0) idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumIds; i++) begin
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                wr_cnt_q[i] <= wr_cnt_d[i];
                rd_cnt_q[i] <= rd_cnt_d[i];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
            idle_q <= idle_d;
        end
    end

    assign err_o  = err_q;
    assign idle_o = idle_q;

endmodule

// File: doc/axi_atop_id_guard.md
# axi_atop_id_guard

Per-ID ordering guard that sits directly upstream of `axi_atomic_filter` on the slave-port request path. It gates AW/AR handshakes so that an atomic transaction (ATOP) is only issued when its ID has nothing outstanding. No further AW/AR with that ID is issued until the atomic's B (and R, if any) responses return. Payload (address, len, atop, W channel) bypasses the block; only valid/ready are gated, and responses are snooped.

## Interface
- `IdWidth`, 4: AXI ID width; tracking is per ID, 2^IdWidth entries.
- `MaxTxns`, 8: maximum outstanding transactions per ID per direction; counter width is `$clog2(MaxTxns+1)`.

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `slv_aw_valid_i` / `slv_aw_ready_o`  in/out  1  upstream AW handshake
- `aw_id_i`  in  IdWidth  AW ID
- `aw_atop_i`  in  6  AW atop
- `mst_aw_valid_o` / `mst_aw_ready_i`  out/in  1  downstream AW handshake
- `slv_ar_valid_i` / `slv_ar_ready_o`  in/out  1  upstream AR handshake
- `ar_id_i`  in  IdWidth  AR ID
- `mst_ar_valid_o` / `mst_ar_ready_i`  out/in  1  downstream AR handshake
- `b_valid_i`, `b_ready_i`  in  1  snooped B handshake
- `b_id_i`  in  IdWidth  B ID
- `r_valid_i`, `r_ready_i`, `r_last_i`  in  1  snooped R handshake
- `r_id_i`  in  IdWidth  R ID
- `idle_o`  out  1  all counters zero and no ID busy
- `err_o`  out  1  one-cycle pulse on a response for an ID with zero count

## Operation
- Per-ID state is registered: `wr_cnt[id]`, `rd_cnt[id]`, `busy[id]`.
- Classification of AW by `aw_atop_i[5:4]`:
  - 00: non-atomic.
  - 01: AtomicStore, B only.
  - 10/11: AtomicLoad/Swap/Compare, B + R.
- AW allow:
  - Non-atomic: `!busy[id] && wr_cnt[id] < MaxTxns`.
  - Atomic: `!busy[id] && wr_cnt[id]==0 && rd_cnt[id]==0`.
- AR allow: `!busy[ar_id] && rd_cnt[ar_id] < MaxTxns`, and not (atomic AW valid with `aw_id_i==ar_id_i`). On this conflict the AW wins and the AR stalls.
- Gating:
  - `mst_x_valid_o = slv_x_valid_i & allow`.
  - `slv_x_ready_o = mst_x_ready_i & allow`.
  - `allow` must not depend on `mst_x_ready_i`.
- AW handshake (`mst_aw_valid_o & mst_aw_ready_i`):
  - Increments `wr_cnt[id]`.
  - Atomic: also sets `busy[id]`.
  - atop[5]=1: also increments `rd_cnt[id]`.
- AR handshake increments `rd_cnt[ar_id]`.
- B handshake decrements `wr_cnt[b_id]`.
- R handshake with `r_last_i` decrements `rd_cnt[r_id]`; non-last beats are ignored.
- Clearing busy: `busy[id]` clears on the edge where the next-state values of both `wr_cnt[id]` and `rd_cnt[id]` are 0.
- Increment and decrement on the same counter in the same cycle: net change 0.
- Decrement when count is 0:
  - Counter stays 0.
  - `err_o` pulses high for the following cycle (registered).
  - `busy` is unaffected.
- `idle_o` is registered: high when every counter is 0 and every `busy` is 0.

## Timing
- Zero-latency combinational pass-through on valid/ready; no added pipeline stage.
- All allow decisions use registered state. A B/R retiring in cycle N does not enable an atomic until cycle N+1, which is conservative by one cycle.
- After an atomic is accepted in cycle N, a same-ID AW/AR is blocked from cycle N+1. Within cycle N, AR same-ID blocking is handled by the conflict rule.
- Reset values: all counters 0, all `busy` 0, `err_o` 0, `idle_o` 1.
- Combinational outputs follow the inputs once out of reset.
- Reset asserted mid-transaction clears all state immediately. Outstanding responses arriving after reset deassertion raise `err_o`.
- Upstream AXI stability applies: once `slv_x_valid_i` is high it stays high with a stable ID until ready. The guard may hold `slv_x_ready_o` low indefinitely while blocked.
- Counter wrap is impossible: increments are blocked at `MaxTxns`.

## Test plan
- **Non-atomic AW burst:**
  - Stimulus: 8 non-atomic AWs with ID 3 and no B.
  - Required: all 8 pass; `wr_cnt[3]`=8; the 9th AW has `slv_aw_ready_o`=0 until one B with ID 3 retires, then passes the following cycle.
- **Atomic waits for outstanding read:**
  - Stimulus: AR ID 5 accepted, then AW ID 5 with atop=6'b100000.
  - Required: AW stalls; R ID 5 with `r_last_i` in cycle N; AW passes in cycle N+1; `busy[5]`=1, `wr_cnt[5]`=1, `rd_cnt[5]`=1.
- **Busy blocks same ID only:**
  - Stimulus: AR ID 5 and AR ID 6 while `busy[5]`.
  - Required: ID 6 passes immediately; ID 5 passes only the cycle after both B and R(last) for ID 5 have retired.
- **AtomicStore completion:**
  - Stimulus: AW ID 2 with atop=6'b010000.
  - Required: `rd_cnt[2]` unchanged; B ID 2 clears `busy[2]`; `idle_o` returns to 1 one cycle later.
- **Same-cycle AW/AR conflict:**
  - Stimulus: atomic AW ID 1 and AR ID 1 valid in the same cycle from idle.
  - Required: AW passes; AR `slv_ar_ready_o`=0 until the atomic completes.
- **Spurious B and reset:**
  - Stimulus: B ID 7 with zero count.
  - Required: `err_o`=1 for exactly one cycle; no counter change.
  - Stimulus: `rst_i` asserted mid-transaction.
  - Required: immediate `idle_o`=1 and all gates open.
